// File: rtl/matmul_stream_sequencer_pkg.sv
// matmul_pkg: shared types and defaults for the multiply2 front/back-end sequencer
package matmul_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_DIM     = 2;
    localparam int DEF_N_ELEM  = DEF_DIM * DEF_DIM;
    localparam int DEF_TIMEOUT = 255;

    typedef logic [DEF_DATA_W-1:0] elem_t;
    typedef elem_t [DEF_DIM-1:0][DEF_DIM-1:0] mat_t;
    typedef logic [$clog2(DEF_N_ELEM)-1:0] idx_t;

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        RUN,
        DRAIN
    } seq_state_e;

endpackage

// File: rtl/matmul_stream_sequencer_if.sv
// matmul_stream_sequencer_if: operand-in and result-out valid/ready byte streams
interface matmul_stream_sequencer_if #(
    parameter int DATA_W = matmul_pkg::DEF_DATA_W
);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/matmul_stream_sequencer.sv
// matmul_stream_sequencer: loads A/B, drives multiply2 start/done, drains C; MATMUL_SEQ_TIMEOUT_EN adds a done watchdog
module matmul_stream_sequencer
    import matmul_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int DIM            = DEF_DIM,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
    input  logic                                clk,
    input  logic                                rst,
    matmul_stream_sequencer_if.slave            s,
    output logic                                busy,
    output logic [DIM-1:0][DIM-1:0][DATA_W-1:0] mat_A,
    output logic [DIM-1:0][DIM-1:0][DATA_W-1:0] mat_B,
    input  logic [DIM-1:0][DIM-1:0][DATA_W-1:0] mat_C,
    input  logic                                done,
`ifdef MATMUL_SEQ_TIMEOUT_EN
    output logic                                error,
`endif
    output logic                                start
);

    localparam int N_ELEM = DIM * DIM;
    localparam int CW     = $clog2(DIM);

    seq_state_e                          state;
    idx_t                                cnt;
    logic [DIM-1:0][DIM-1:0][DATA_W-1:0] c_q;
    logic [CW-1:0]                       row, col;
    logic                                acc, hs, last;

    assign row  = CW'(cnt / DIM);
    assign col  = CW'(cnt % DIM);
    assign last = cnt == idx_t'(N_ELEM - 1);
    assign acc  = s.in_valid & s.in_ready;
    assign hs   = s.out_valid & s.out_ready;

    assign s.in_ready  = state == LOAD_A || state == LOAD_B;
    assign s.out_valid = state == DRAIN;
    assign s.out_data  = s.out_valid ? c_q[row][col] : '0;
    assign s.out_last  = s.out_valid && last;
    assign start       = state == RUN;
    assign busy        = !(state == LOAD_A && cnt == '0);

`ifdef MATMUL_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmr;
    logic          tmo;
    assign tmo = tmr == TW'(TIMEOUT_CYCLES - 1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD_A;
            cnt   <= '0;
            mat_A <= '0;
            mat_B <= '0;
            c_q   <= '0;
`ifdef MATMUL_SEQ_TIMEOUT_EN
            tmr   <= '0;
            error <= 1'b0;
`endif
        end else begin
            case (state)
                LOAD_A: if (acc) begin
                    mat_A[row][col] <= s.in_data;
                    cnt             <= last ? '0 : cnt + idx_t'(1);
                    if (last) state <= LOAD_B;
                end
                LOAD_B: if (acc) begin
                    mat_B[row][col] <= s.in_data;
                    cnt             <= last ? '0 : cnt + idx_t'(1);
                    if (last) state <= RUN;
                end
                RUN: if (done) begin
                    c_q   <= mat_C;
                    state <= DRAIN;
                end
`ifdef MATMUL_SEQ_TIMEOUT_EN
                else if (tmo) begin
                    state <= LOAD_A;
                    error <= 1'b1;
                end
`endif
                DRAIN: if (hs) begin
                    cnt <= last ? '0 : cnt + idx_t'(1);
                    if (last) state <= LOAD_A;
                end
                default: state <= LOAD_A;
            endcase
`ifdef MATMUL_SEQ_TIMEOUT_EN
            // cycles spent in RUN without done; cleared on any exit
            tmr <= (state == RUN && !done && !tmo) ? tmr + TW'(1) : '0;
`endif
        end
    end

endmodule

// File: tb/tb_matmul_stream_sequencer.sv
// tb_matmul_stream_sequencer: directed bench with a multiply2 stub that raises done after 3 start cycles
module tb_matmul_stream_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, start, done;
    logic [1:0][1:0][7:0] mat_A, mat_B, mat_C;
`ifdef MATMUL_SEQ_TIMEOUT_EN
    logic error;
`endif
    logic force_done = 1'b0;
    logic stall_done = 1'b0;
    logic [2:0] st_cnt;
    logic [7:0] vec [8];
    logic [7:0] exp_c [4];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    matmul_stream_sequencer_if #(.DATA_W(8)) bus ();

    matmul_stream_sequencer dut (
        .clk   (clk),
        .rst   (rst),
        .s     (bus.slave),
        .busy  (busy),
        .mat_A (mat_A),
        .mat_B (mat_B),
        .mat_C (mat_C),
        .done  (done),
`ifdef MATMUL_SEQ_TIMEOUT_EN
        .error (error),
`endif
        .start (start)
    );

    always_ff @(posedge clk) st_cnt <= start ? (st_cnt == 3'd3 ? 3'd3 : st_cnt + 3'd1) : 3'd0;
    assign done = force_done | (start && st_cnt == 3'd3 && !stall_done);

    always_comb begin
        mat_C = '0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                mat_C[i][j] = 8'(mat_A[i][0] * mat_B[0][j] + mat_A[i][1] * mat_B[1][j]);
    end

    task automatic send(input logic [7:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic load(input int first, input int last, input int gap);
        for (int k = first; k < last; k++) begin
            checks++;
            if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL load_in_ready[%0d]: got %b expected 1", k, bus.in_ready); end
            if (k == 7) begin
                checks++;
                if (start !== 1'b0) begin failures++; $display("FAIL start_early: got %b expected 0", start); end
            end
            send(vec[k]);
            if (k == 7) begin
                checks++;
                if (start !== 1'b1) begin failures++; $display("FAIL start_after_8th: got %b expected 1", start); end
            end
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic wait_out();
        int cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < 20) begin
            checks++;
            if (bus.in_ready !== 1'b0 || start !== 1'b1) begin
                failures++; $display("FAIL run_signals: got in_ready=%b start=%b expected 0/1", bus.in_ready, start);
            end
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL wait_out_valid: got %b expected 1 within 20 cycles", bus.out_valid); end
        checks++;
        if (start !== 1'b0) begin failures++; $display("FAIL start_in_drain: got %b expected 0", start); end
    endtask

    task automatic drain(input bit toggle);
        logic [3:0] pat = 4'b1001;
        int k = 0;
        int cyc = 0;
        while (k < 4 && cyc < 40) begin
            bus.out_ready = toggle ? pat[3 - (cyc % 4)] : 1'b1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp_c[k] || bus.out_last !== (k == 3) || bus.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL drain[%0d]: got valid=%b data=%0d last=%b in_ready=%b expected 1/%0d/%b/0",
                         k, bus.out_valid, bus.out_data, bus.out_last, bus.in_ready, exp_c[k], k == 3);
            end
            @(posedge clk); #1;
            if (bus.out_ready) k++;
            cyc++;
        end
        bus.out_ready = 1'b0;
        checks++;
        if (k != 4) begin failures++; $display("FAIL drain_count: got %0d handshakes expected 4", k); end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL post_drain: got valid=%b in_ready=%b busy=%b expected 0/1/0", bus.out_valid, bus.in_ready, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL extra_output: got out_valid=%b expected 0", bus.out_valid); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.out_data !== 8'd0
            || start !== 1'b0 || busy !== 1'b0 || mat_A !== 32'd0 || mat_B !== 32'd0) begin
            failures++;
            $display("FAIL reset_state: got in_ready=%b out_valid=%b last=%b data=%0d start=%b busy=%b A=%h B=%h expected 1/0/0/0/0/0/0/0",
                     bus.in_ready, bus.out_valid, bus.out_last, bus.out_data, start, busy, mat_A, mat_B);
        end
    endtask

    task automatic test_basic();
        vec   = '{8'd2, 8'd2, 8'd2, 8'd2, 8'd4, 8'd4, 8'd4, 8'd4};
        exp_c = '{8'd16, 8'd16, 8'd16, 8'd16};
        load(0, 8, 0);
        checks++;
        if (mat_A !== 32'h02020202 || mat_B !== 32'h04040404) begin
            failures++; $display("FAIL basic_operands: got A=%h B=%h expected 02020202/04040404", mat_A, mat_B);
        end
        wait_out();
        drain(1'b0);
    endtask

    task automatic test_gaps();
        vec   = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        exp_c = '{8'd19, 8'd22, 8'd43, 8'd50};
        load(0, 8, 1);
        wait_out();
        drain(1'b0);
        checks++;
        if (mat_A !== 32'h04030201 || mat_B !== 32'h08070605) begin
            failures++; $display("FAIL operands_held: got A=%h B=%h expected 04030201/08070605", mat_A, mat_B);
        end
    endtask

    task automatic test_stall();
        vec   = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        exp_c = '{8'd19, 8'd22, 8'd43, 8'd50};
        load(0, 8, 0);
        wait_out();
        drain(1'b1);
    endtask

    task automatic test_reset_in_run();
        vec = '{8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9};
        load(0, 8, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (start !== 1'b0 || bus.out_valid !== 1'b0 || mat_A !== 32'd0 || mat_B !== 32'd0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_run: got start=%b out_valid=%b A=%h B=%h in_ready=%b busy=%b expected 0/0/0/0/1/0",
                     start, bus.out_valid, mat_A, mat_B, bus.in_ready, busy);
        end
        vec   = '{8'd1, 8'd0, 8'd0, 8'd1, 8'd3, 8'd5, 8'd7, 8'd9};
        exp_c = '{8'd3, 8'd5, 8'd7, 8'd9};
        load(0, 8, 0);
        wait_out();
        drain(1'b0);
    endtask

    task automatic test_done_outside_run();
        vec   = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd2, 8'd3, 8'd4};
        exp_c = '{8'd4, 8'd6, 8'd4, 8'd6};
        load(0, 6, 0);
        force_done = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || start !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL done_in_load_b: got out_valid=%b in_ready=%b start=%b busy=%b expected 0/1/0/1",
                         bus.out_valid, bus.in_ready, start, busy);
            end
        end
        force_done = 1'b0;
        load(6, 8, 0);
        wait_out();
        drain(1'b0);
    endtask

`ifdef MATMUL_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0;
        vec = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
        stall_done = 1'b1;
        load(0, 8, 0);
        while (start === 1'b1 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n != 255) begin failures++; $display("FAIL timeout_cycles: got %0d expected 255", n); end
        checks++;
        if (error !== 1'b1 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL timeout_state: got error=%b in_ready=%b out_valid=%b expected 1/1/0", error, bus.in_ready, bus.out_valid);
        end
        repeat (5) begin @(posedge clk); #1; end
        checks++;
        if (error !== 1'b1) begin failures++; $display("FAIL error_sticky: got %b expected 1", error); end
        stall_done = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (error !== 1'b0) begin failures++; $display("FAIL error_reset: got %b expected 0", error); end
    endtask
`endif

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_gaps();
        test_stall();
        test_reset_in_run();
        test_done_outside_run();
`ifdef MATMUL_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
